nrf_spi_byte_master: RTL

- Byte-level SPI master that drives the physical SPI pins (csn, sck, mosi, miso) of one nRF24L01 radio.
- Sits directly downstream of the nRF command/payload controller. The controller hands it command, register and payload bytes over a valid/ready stream and gets the full-duplex received bytes back.
- Generates SCK internally from the 50 MHz system clock and owns CSN framing, so the radio sees one CSN-low window per command.
- One instance per radio: one for TX, one for RX.

---
 rtl/nrf_spi_byte_master.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nrf_spi_byte_master.sv
// nrf_spi_byte_master: byte-level SPI master (mode 0, MSB first) for one
// nRF24L01 radio. Generates SCK from clk_50, owns CSN framing (one CSN-low
// window per command) and returns full-duplex received bytes.
// Optional feature macro: NRF_STATUS_CAPTURE_EN (latch first rx byte of each
// transaction, the nRF STATUS register, onto the status port).
module nrf_spi_byte_master #(
  parameter int unsigned HALF_PERIOD = 3,
  parameter int unsigned CSN_SETUP   = 2,
  parameter int unsigned CSN_HOLD    = 2,
  parameter int unsigned CSN_IDLE    = 4
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       csn,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sh;
  logic [7:0] rx_sh;
  logic       last_q;
  logic       accept;
  logic       byte_done;

  // Handshake and end-of-byte strobes shared by the FSM and status capture
  always_comb begin
    accept    = tx_valid && tx_ready;
    byte_done = (state == ST_SHIFT) && sck && (cnt == '0) && (bit_cnt == '0);
  end

  // Main FSM: CSN framing, SCK generation, MOSI shifting and MISO sampling
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      last_q   <= 1'b0;
      csn      <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_ready <= 1'b1;
          if (accept) begin
            state    <= ST_SETUP;
            csn      <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            mosi     <= tx_data[7];
            tx_sh    <= tx_data[6:0];
            last_q   <= tx_last;
            cnt      <= 8'(CSN_SETUP - 1);
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            state   <= ST_SHIFT;
            cnt     <= 8'(HALF_PERIOD - 1);
            bit_cnt <= '1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            cnt <= 8'(HALF_PERIOD - 1);
            if (!sck) begin
              // Rising edge: sample miso on the same clk_50 edge
              sck   <= 1'b1;
              rx_sh <= {rx_sh[6:0], miso};
            end else begin
              sck <= 1'b0;
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 3'd1;
                mosi    <= tx_sh[6];
                tx_sh   <= {tx_sh[5:0], 1'b0};
              end else begin
                // Eighth falling edge: mosi keeps the last bit
                rx_valid <= 1'b1;
                rx_data  <= rx_sh;
                if (last_q) begin
                  state <= ST_HOLD;
                  cnt   <= 8'(CSN_HOLD - 1);
                end else begin
                  state    <= ST_WAIT;
                  tx_ready <= 1'b1;
                end
              end
            end
          end
        end

        ST_WAIT: begin
          if (accept) begin
            state    <= ST_SHIFT;
            tx_ready <= 1'b0;
            mosi     <= tx_data[7];
            tx_sh    <= tx_data[6:0];
            last_q   <= tx_last;
            cnt      <= 8'(HALF_PERIOD - 1);
            bit_cnt  <= '1;
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_GAP;
            csn   <= 1'b1;
            cnt   <= 8'(CSN_IDLE - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          csn   <= 1'b1;
          sck   <= 1'b0;
        end
      endcase
    end
  end

`ifdef NRF_STATUS_CAPTURE_EN
  logic first_pending;

  // Latch the first received byte of each transaction (nRF STATUS)
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      status        <= '0;
      first_pending <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && accept) begin
        first_pending <= 1'b1;
      end else if (byte_done && first_pending) begin
        status        <= rx_sh;
        first_pending <= 1'b0;
      end
    end
  end
`else
  assign status = '0;
`endif

endmodule
